// File: rtl/bpm_beat_generator_pkg.sv
// Shared widths and FSM encoding for the BPM beat generator.
package bpm_gen_pkg;
  localparam int BPM_W         = 16;
  localparam int DIV_W         = 32;
  localparam int BEATS_PER_BAR = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    LOAD   = 2'd2
  } state_t;
endpackage

// File: rtl/bpm_beat_generator_if.sv
// Tempo input handshake from the BPM estimator into the beat generator.
interface bpm_beat_generator_if;
  logic [bpm_gen_pkg::BPM_W-1:0] bpm_in;
  logic                          bpm_in_valid;
  logic                          bpm_in_ready;

  modport master (output bpm_in, output bpm_in_valid, input  bpm_in_ready);
  modport slave  (input  bpm_in, input  bpm_in_valid, output bpm_in_ready);
endinterface

// File: rtl/bpm_beat_generator_seq_divider.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle, fixed 32-cycle latency.
module seq_divider
  import bpm_gen_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dsr_q, dsr_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DIV_W:0]   trial;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q, quo_q[DIV_W-1]};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
      cnt_d  = 6'(DIV_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = DIV_W'(trial - {1'b0, dsr_q});
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the final step; the finished quotient is visible the cycle after.
  assign done     = busy_q && (cnt_q == 6'd1);
  assign busy     = busy_q;
  assign quotient = quo_q;
endmodule

// File: rtl/bpm_beat_generator.sv
// Turns accepted BPM values into a beat period and regenerates beat pulse, bar index and LED strobe.
//   state  | meaning
//   IDLE   | ready for a new tempo; out-of-range and repeated values are dropped
//   DIVIDE | computing (CLK_HZ*60)/bpm in the sequential divider
//   LOAD   | publish the new period and mark the generator locked
module bpm_beat_generator
  import bpm_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BPM_MIN        = 40,
  parameter int unsigned BPM_MAX        = 240,
  parameter int unsigned STRETCH_CYCLES = 2_500_000
) (
  input  logic                 clk,
  input  logic                 reset,
  bpm_beat_generator_if.slave  bpm_if,
  output logic [DIV_W-1:0]     period_cycles,
  output logic                 locked,
  output logic                 beat_pulse,
  output logic [1:0]           beat_index,
  output logic                 beat_led
);
  localparam logic [DIV_W-1:0] DIVIDEND     = DIV_W'(CLK_HZ * 60);
  localparam logic [BPM_W-1:0] BPM_LO       = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] BPM_HI       = BPM_W'(BPM_MAX);
  localparam logic [31:0]      STRETCH_LOAD = 32'(STRETCH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic [BPM_W-1:0] last_bpm_q, last_bpm_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             first_q, first_d;
  logic             ready_q, ready_d;
  logic [1:0]       index_q, index_d;
  logic [31:0]      stretch_q, stretch_d;

  logic             div_start, div_busy, div_done;
  logic [DIV_W-1:0] div_quotient;
  logic             in_range, accept, beat;

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  ({{(DIV_W-BPM_W){1'b0}}, bpm_if.bpm_in}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign in_range = (bpm_if.bpm_in >= BPM_LO) && (bpm_if.bpm_in <= BPM_HI);
  assign accept   = (state_q == IDLE) && ready_q && bpm_if.bpm_in_valid && in_range &&
                    (bpm_if.bpm_in != last_bpm_q);

  always_comb begin
    state_d    = state_q;
    bpm_d      = bpm_q;
    last_bpm_d = last_bpm_q;
    period_d   = period_q;
    locked_d   = locked_q;
    first_d    = 1'b0;
    div_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bpm_d     = bpm_if.bpm_in;
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done)       state_d = LOAD;
        else if (!div_busy) state_d = IDLE;
      end
      LOAD: begin
        period_d   = div_quotient;
        last_bpm_d = bpm_q;
        locked_d   = 1'b1;
        first_d    = !locked_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // The very first lock forces a beat; later tempo changes keep the running phase.
  assign beat = locked_q && (first_q || (phase_q >= period_q - 32'd1));

  always_comb begin
    phase_d   = phase_q;
    index_d   = index_q;
    stretch_d = stretch_q;
    if ((state_q == LOAD) && !locked_q) begin
      phase_d = '0;
    end else if (locked_q) begin
      if (beat) begin
        phase_d = '0;
        index_d = index_q + 2'd1;
      end else begin
        phase_d = phase_q + 32'd1;
      end
    end
    if (beat)                   stretch_d = STRETCH_LOAD;
    else if (stretch_q != '0)   stretch_d = stretch_q - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bpm_q      <= '0;
      last_bpm_q <= '0;
      period_q   <= '0;
      phase_q    <= '0;
      locked_q   <= 1'b0;
      first_q    <= 1'b0;
      ready_q    <= 1'b0;
      index_q    <= '0;
      stretch_q  <= '0;
    end else begin
      state_q    <= state_d;
      bpm_q      <= bpm_d;
      last_bpm_q <= last_bpm_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      first_q    <= first_d;
      ready_q    <= ready_d;
      index_q    <= index_d;
      stretch_q  <= stretch_d;
    end
  end

  assign bpm_if.bpm_in_ready = ready_q;
  assign period_cycles       = period_q;
  assign locked              = locked_q;
  assign beat_pulse          = beat;
  assign beat_index          = index_q;
  assign beat_led            = beat || (stretch_q != '0);
endmodule

// File: tb/tb_bpm_beat_generator.sv
// Directed bench for bpm_beat_generator at CLK_HZ=6000 (dividend 360000), STRETCH_CYCLES=100.
module tb_bpm_beat_generator;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] period_cycles;
  logic        locked, beat_pulse, beat_led;
  logic [1:0]  beat_index;

  int n_tests = 0;
  int n_fail  = 0;

  bpm_beat_generator_if bif ();

  bpm_beat_generator #(
    .CLK_HZ         (6000),
    .BPM_MIN        (40),
    .BPM_MAX        (240),
    .STRETCH_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bpm_if        (bif),
    .period_cycles (period_cycles),
    .locked        (locked),
    .beat_pulse    (beat_pulse),
    .beat_index    (beat_index),
    .beat_led      (beat_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bpm;
    logic        acc;
    logic [31:0] period;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns the number of negedges until the next beat_pulse; -1 on timeout.
  task automatic wait_beat(input int max_cyc, output int gap);
    gap = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (beat_pulse) begin
        gap = n;
        break;
      end
    end
    if (gap < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_beat: got no beat expected one within %0d cycles", max_cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bif.bpm_in_ready), 32'd0);
    chk({tag, "_period"}, period_cycles,          32'd0);
    chk({tag, "_locked"}, 32'(locked),            32'd0);
    chk({tag, "_pulse"},  32'(beat_pulse),        32'd0);
    chk({tag, "_index"},  32'(beat_index),        32'd0);
    chk({tag, "_led"},    32'(beat_led),          32'd0);
  endtask

  initial begin
    int gap, low, beat_at, nbeats, last_n;

    vecs[0]  = '{16'd30,  1'b0, 32'd3000};
    vecs[1]  = '{16'd250, 1'b0, 32'd3000};
    vecs[2]  = '{16'd120, 1'b0, 32'd3000};
    vecs[3]  = '{16'd39,  1'b0, 32'd3000};
    vecs[4]  = '{16'd40,  1'b1, 32'd9000};
    vecs[5]  = '{16'd241, 1'b0, 32'd9000};
    vecs[6]  = '{16'd240, 1'b1, 32'd1500};
    vecs[7]  = '{16'd240, 1'b0, 32'd1500};
    vecs[8]  = '{16'd97,  1'b1, 32'd3711};
    vecs[9]  = '{16'd60,  1'b1, 32'd6000};
    vecs[10] = '{16'd0,   1'b0, 32'd6000};
    vecs[11] = '{16'd90,  1'b1, 32'd4000};

    reset            = 1'b1;
    bif.bpm_in       = '0;
    bif.bpm_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready_after", 32'(bif.bpm_in_ready), 32'd1);

    // First lock at 120 BPM with valid held.
    bif.bpm_in       = 16'd120;
    bif.bpm_in_valid = 1'b1;
    low = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (!bif.bpm_in_ready) low++;
      if (k == 33) begin
        chk("t1_period_before", period_cycles, 32'd0);
        chk("t1_locked_before", 32'(locked), 32'd0);
      end
    end
    chk("t1_ready_low_cycles", 32'(low), 32'd33);
    chk("t1_period", period_cycles, 32'd3000);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_first_pulse", 32'(beat_pulse), 32'd1);
    chk("t1_first_index", 32'(beat_index), 32'd0);
    chk("t1_ready_back", 32'(bif.bpm_in_ready), 32'd1);
    repeat (99) @(negedge clk);
    chk("t1_led_last_high", 32'(beat_led), 32'd1);
    @(negedge clk);
    chk("t1_led_low", 32'(beat_led), 32'd0);
    wait_beat(4000, gap);
    chk("t1_gap1", 32'(gap), 32'd2900);
    chk("t1_index1", 32'(beat_index), 32'd1);
    for (int b = 2; b <= 4; b++) begin
      wait_beat(4000, gap);
      chk("t1_gap", 32'(gap), 32'd3000);
      chk("t1_index", 32'(beat_index), 32'(b % 4));
    end

    // Out-of-range values while locked are ignored.
    bif.bpm_in = 16'd30;
    low = 0;
    beat_at = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1500) bif.bpm_in = 16'd250;
      if (!bif.bpm_in_ready) low++;
      if (beat_pulse && beat_at == 0) beat_at = n;
    end
    bif.bpm_in = 16'd120;
    chk("t2_ready_low", 32'(low), 32'd0);
    chk("t2_beat_gap", 32'(beat_at), 32'd3000);
    chk("t2_period", period_cycles, 32'd3000);

    // Slower tempo with counter at 2000: beat when counter reaches 3999.
    repeat (2001) @(negedge clk);
    bif.bpm_in = 16'd90;
    wait_beat(5000, gap);
    chk("t3_gap_to_beat", 32'(gap), 32'd1999);
    chk("t3_period", period_cycles, 32'd4000);
    wait_beat(5000, gap);
    chk("t3_gap", 32'(gap), 32'd4000);

    // Back to 120, then faster tempo with counter past the new period.
    bif.bpm_in = 16'd120;
    wait_beat(5000, gap);
    chk("t4_gap_120", 32'(gap), 32'd3000);
    repeat (2501) @(negedge clk);
    bif.bpm_in = 16'd240;
    wait_beat(100, gap);
    chk("t4_beat_after_load", 32'(gap), 32'd34);
    chk("t4_period", period_cycles, 32'd1500);
    wait_beat(2000, gap);
    chk("t4_gap", 32'(gap), 32'd1500);

    // Non-integer quotient, then a long hold of the same value.
    bif.bpm_in = 16'd97;
    wait_beat(5000, gap);
    chk("t5_gap_first", 32'(gap), 32'd3711);
    chk("t5_period", period_cycles, 32'd3711);
    low = 0;
    nbeats = 0;
    last_n = 0;
    for (int n = 1; n <= 10000; n++) begin
      @(negedge clk);
      if (!bif.bpm_in_ready) low++;
      if (beat_pulse) begin
        nbeats++;
        last_n = n;
      end
    end
    chk("t5_ready_low", 32'(low), 32'd0);
    chk("t5_beats", 32'(nbeats), 32'd2);
    chk("t5_last_beat", 32'(last_n), 32'd7422);

    // Reset ten cycles into a divide.
    bif.bpm_in = 16'd200;
    repeat (10) @(negedge clk);
    reset            = 1'b1;
    bif.bpm_in_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6");
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", 32'(bif.bpm_in_ready), 32'd1);
    bif.bpm_in       = 16'd120;
    bif.bpm_in_valid = 1'b1;
    repeat (34) @(negedge clk);
    chk("t6_period", period_cycles, 32'd3000);
    chk("t6_locked", 32'(locked), 32'd1);
    chk("t6_pulse", 32'(beat_pulse), 32'd1);
    @(negedge clk);
    chk("t6_pulse_single", 32'(beat_pulse), 32'd0);
    wait_beat(4000, gap);
    chk("t6_gap", 32'(gap), 32'd2999);
    chk("t6_index", 32'(beat_index), 32'd1);

    // Table: one-cycle transfers, acceptance and resulting period.
    bif.bpm_in_valid = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      bif.bpm_in       = vecs[i].bpm;
      bif.bpm_in_valid = 1'b1;
      @(negedge clk);
      bif.bpm_in_valid = 1'b0;
      chk($sformatf("vec%0d_ready", i), 32'(bif.bpm_in_ready), 32'(!vecs[i].acc));
      repeat (36) @(negedge clk);
      chk($sformatf("vec%0d_period", i), period_cycles, vecs[i].period);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
